// File: rtl/mux_pkg.sv
// Shared constants for the round-robin / manual channel multiplexer.
//   MODE_MANUAL : mode value selecting the channel given on sel
//   MODE_RR     : mode value selecting round-robin scanning of in_valid
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: finds the first requesting channel after ptr,
// wrapping around.
// Purely combinational.
//   req     : per-channel request vector
//   ptr     : last granted channel; the search starts at ptr+1
//   grant   : one-hot grant; all zero when nothing requests
//   gnt_idx : index of the granted channel; 0 when nothing requests
//   any     : at least one channel requests
module rr_pick #(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    gnt_idx,
  output logic                any
);

  logic [2*CHANNELS-1:0] dbl;
  logic [CHANNELS-1:0]   rot;
  int                    start;
  int                    pick;

  always_comb begin
    start = (int'(ptr) + 1) % CHANNELS;
    // Rotate so that bit 0 of rot is the channel right after ptr.
    dbl   = {req, req} >> start;
    rot   = dbl[CHANNELS-1:0];
    pick  = -1;
    for (int j = 0; j < CHANNELS; j++) begin
      if (pick < 0 && rot[j]) pick = (start + j) % CHANNELS;
    end
    any = (pick >= 0);
    for (int k = 0; k < CHANNELS; k++) begin
      grant[k] = (k == pick);
    end
    gnt_idx = any ? SEL_W'(pick) : '0;
  end

endmodule

// File: rtl/mux_rr_n.sv
// N-channel multiplexer into a single registered output slice.
// Channel selection is either manual (sel) or round-robin over in_valid.
//   clk, rst_n : clock, asynchronous active-low reset
//   mode       : 0 manual select, 1 round-robin scan
//   sel        : channel index used in manual mode
//   in_data    : channel k at [k*WIDTH +: WIDTH]
//   in_valid   : per-channel valid
//   in_ready   : one-hot combinational accept for this cycle
//   out_data   : registered selected word
//   out_valid  : out_data is valid
//   out_ch     : index of the channel that supplied out_data
//   out_ready  : downstream accepts when out_valid & out_ready
module mux_rr_n
  import mux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          out_ch,
  input  logic                      out_ready
);

  logic [SEL_W-1:0]    ptr;
  logic [CHANNELS-1:0] rr_grant;
  logic [SEL_W-1:0]    rr_idx;
  logic                rr_any;
  logic [CHANNELS-1:0] man_grant;
  logic                man_any;
  logic                free;
  logic                gnt_any;
  logic [SEL_W-1:0]    gnt_idx;
  logic [WIDTH-1:0]    gnt_data;

  rr_pick #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_rr_pick (
    .req     (in_valid),
    .ptr     (ptr),
    .grant   (rr_grant),
    .gnt_idx (rr_idx),
    .any     (rr_any)
  );

  // Out-of-range sel values match no channel, so they never grant.
  always_comb begin
    man_grant = '0;
    man_any   = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel == SEL_W'(k) && in_valid[k]) begin
        man_grant[k] = 1'b1;
        man_any      = 1'b1;
      end
    end
  end

  // Grants are suppressed while reset is held so nothing is accepted
  // upstream that the register would then drop.
  always_comb begin
    free     = !out_valid || out_ready;
    in_ready = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    if (free && rst_n) begin
      if (mode == MODE_RR) begin
        in_ready = rr_grant;
        gnt_any  = rr_any;
        gnt_idx  = rr_idx;
      end else begin
        in_ready = man_grant;
        gnt_any  = man_any;
        gnt_idx  = sel;
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (in_ready[k]) gnt_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  // ptr resets to the last channel so that channel 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= SEL_W'(CHANNELS - 1);
    end else if (free) begin
      if (gnt_any) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_ch    <= gnt_idx;
        if (mode == MODE_RR) ptr <= gnt_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_n.sv
// Directed bench for mux_rr_n with an expected-word queue per DUT;
// a negedge monitor pops and compares on every accepted output word.
module tb_mux_rr_n;

  typedef struct {
    logic [7:0] d;
    logic [2:0] ch;
  } exp_t;

  typedef struct {
    logic       d;
    logic       ch;
  } exp2_t;

  logic        clk = 1'b1;
  logic        rst_n;
  logic        mode;
  logic [2:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [2:0]  out_ch;
  logic        out_ready;

  logic        mode2;
  logic        sel2;
  logic [1:0]  in_data2;
  logic [1:0]  in_valid2;
  logic [1:0]  in_ready2;
  logic        out_data2;
  logic        out_valid2;
  logic        out_ch2;
  logic        out_ready2;

  exp_t  exp_q[$];
  exp2_t exp2_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    ptr2_m;

  always #5 clk = ~clk;

  mux_rr_n #(.WIDTH(8), .CHANNELS(4), .SEL_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  mux_rr_n #(.WIDTH(1), .CHANNELS(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode2),
    .sel       (sel2),
    .in_data   (in_data2),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .out_data  (out_data2),
    .out_valid (out_valid2),
    .out_ch    (out_ch2),
    .out_ready (out_ready2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic [2:0] ch);
    exp_t e;
    e.d  = d;
    e.ch = ch;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    tick();
    rst_n  = 1'b1;
    ptr2_m = 1;
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {21'd0, out_ch, out_data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("word_data", {24'd0, out_data}, {24'd0, e.d});
        chk("word_ch", {29'd0, out_ch}, {29'd0, e.ch});
      end
    end
    if (out_valid2 && out_ready2) begin
      if (exp2_q.size() == 0) begin
        chk("sweep_unexpected", {30'd0, out_ch2, out_data2}, 32'hFFFF_FFFF);
      end else begin
        exp2_t e2;
        e2 = exp2_q.pop_front();
        chk("sweep_data", {31'd0, out_data2}, {31'd0, e2.d});
        chk("sweep_ch", {31'd0, out_ch2}, {31'd0, e2.ch});
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    mode       = 1'b1;
    sel        = 3'd0;
    in_data    = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    in_valid   = 4'b0000;
    out_ready  = 1'b0;
    mode2      = 1'b0;
    sel2       = 1'b0;
    in_data2   = 2'b00;
    in_valid2  = 2'b00;
    out_ready2 = 1'b1;
    ptr2_m     = 1;

    // Reset state, then a word dropped by a mid-cycle reset at 25 ns.
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    tick();
    rst_n    = 1'b1;
    in_valid = 4'b0001;
    tick();
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #4;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_data", {24'd0, out_data}, 32'd0);
    chk("async_rst_ch", {29'd0, out_ch}, 32'd0);
    chk("rst_no_grant", {28'd0, in_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {28'd0, in_ready}, 32'h1);
    push(8'hA0, 3'd0);
    tick();
    chk("post_rst_ch", {29'd0, out_ch}, 32'd0);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    tick();
    chk("idle_valid", {31'd0, out_valid}, 32'd0);

    // Full round-robin 0,1,2,3,0 with no bubbles.
    do_reset();
    in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_ready", {28'd0, in_ready}, 32'd1 << (i % 4));
      push(8'hA0 + 8'(i % 4), 3'(i % 4));
      if (i > 0) chk("rr_no_bubble", {31'd0, out_valid}, 32'd1);
      tick();
    end
    in_valid = 4'b0000;
    tick();
    chk("rr_drain_valid", {31'd0, out_valid}, 32'd0);

    // Sparse requests with wrap; ptr holds across an idle cycle.
    do_reset();
    in_valid = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("sparse_ready", {28'd0, in_ready}, (i % 2 == 0) ? 32'h1 : 32'h8);
      push((i % 2 == 0) ? 8'hA0 : 8'hA3, (i % 2 == 0) ? 3'd0 : 3'd3);
      tick();
    end
    in_valid = 4'b0000;
    tick();
    chk("sparse_idle_valid", {31'd0, out_valid}, 32'd0);
    in_valid = 4'b1111;
    #1;
    chk("ptr_held", {28'd0, in_ready}, 32'h1);
    push(8'hA0, 3'd0);
    tick();
    in_valid = 4'b0000;
    tick();

    // Backpressure for three cycles.
    do_reset();
    in_valid = 4'b1111;
    #1;
    chk("bp_first_ready", {28'd0, in_ready}, 32'h1);
    push(8'hA0, 3'd0);
    tick();
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("bp_ready_low", {28'd0, in_ready}, 32'd0);
      chk("bp_data_hold", {24'd0, out_data}, 32'hA0);
      chk("bp_valid_hold", {31'd0, out_valid}, 32'd1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {28'd0, in_ready}, 32'h2);
    push(8'hA1, 3'd1);
    tick();
    chk("bp_next_data", {24'd0, out_data}, 32'hA1);
    chk("bp_next_ch", {29'd0, out_ch}, 32'd1);
    in_valid = 4'b0000;
    tick();

    // Manual mode, out-of-range sel, invalid channel, mode switching.
    mode     = 1'b0;
    sel      = 3'd2;
    in_valid = 4'b0100;
    #1;
    chk("man_ready", {28'd0, in_ready}, 32'h4);
    push(8'hA2, 3'd2);
    tick();
    chk("man_out_ch", {29'd0, out_ch}, 32'd2);
    sel      = 3'd5;
    in_valid = 4'b1111;
    #1;
    chk("man_oob_ready", {28'd0, in_ready}, 32'd0);
    tick();
    chk("man_oob_valid", {31'd0, out_valid}, 32'd0);
    sel      = 3'd1;
    in_valid = 4'b0100;
    #1;
    chk("man_invalid_ready", {28'd0, in_ready}, 32'd0);
    tick();
    chk("man_invalid_valid", {31'd0, out_valid}, 32'd0);
    mode     = 1'b1;
    in_valid = 4'b1111;
    #1;
    chk("switch_rr_ready", {28'd0, in_ready}, 32'h4);
    push(8'hA2, 3'd2);
    tick();
    mode = 1'b0;
    sel  = 3'd3;
    #1;
    chk("switch_man_ready", {28'd0, in_ready}, 32'h8);
    push(8'hA3, 3'd3);
    tick();
    in_valid = 4'b0000;
    tick();

    // Exhaustive sweep of the 2-channel, 1-bit instance.
    do_reset();
    for (int m = 0; m < 2; m++) begin
      for (int s = 0; s < 2; s++) begin
        for (int v = 0; v < 4; v++) begin
          for (int d = 0; d < 4; d++) begin
            logic [1:0] vv;
            logic [1:0] dd;
            int         g;
            int         c;
            exp2_t      e2;
            vv        = 2'(v);
            dd        = 2'(d);
            mode2     = 1'(m);
            sel2      = 1'(s);
            in_valid2 = vv;
            in_data2  = dd;
            g = -1;
            if (m == 1) begin
              if (vv != 2'b00) begin
                c = (ptr2_m + 1) % 2;
                g = vv[c] ? c : 1 - c;
                ptr2_m = g;
              end
            end else if (vv[s]) begin
              g = s;
            end
            #1;
            chk("sweep_ready", {30'd0, in_ready2}, (g >= 0) ? (32'd1 << g) : 32'd0);
            if (g >= 0) begin
              e2.d  = dd[g];
              e2.ch = 1'(g);
              exp2_q.push_back(e2);
            end
            tick();
          end
        end
      end
    end
    in_valid2 = 2'b00;
    tick();
    tick();
    tick();

    chk("queue_drained", exp_q.size(), 32'd0);
    chk("sweep_queue_drained", exp2_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
